// File: rtl/retire_mon_pkg.sv
// Shared types and helpers for the retire monitor: error codes, cycle-stamp width,
// and lane-mask utilities sized for the widest supported retire group.
package retire_mon_pkg;

  localparam int CYCLE_W   = 32;
  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MEM_RW    = 2'd1,
    ERR_LANE_GAP  = 2'd2,
    ERR_POST_HALT = 2'd3
  } err_code_e;

  function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

  // A mask packed from bit 0 upward is one less than a power of two.
  function automatic logic is_thermo(input logic [MAX_LANES-1:0] v);
    return (v & (v + MAX_LANES'(1))) == '0;
  endfunction

endpackage

// File: rtl/retire_hist_buf.sv
// Circular buffer of recently retired PCs; accepts up to NRET writes per cycle in
// lane order and reads combinationally with index 0 being the newest entry.
module retire_hist_buf
  import retire_mon_pkg::*;
#(
  parameter  int NRET       = 2,
  parameter  int HIST_DEPTH = 8,
  localparam int IDX_W      = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRET-1:0]    wr_valid,
  input  logic [NRET*32-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [31:0]        rd_data
);

  logic [31:0]      mem_q [HIST_DEPTH];
  logic [31:0]      mem_d [HIST_DEPTH];
  logic [IDX_W-1:0] wptr_q, wptr_d;

  // Valid lanes take consecutive slots, so a gapped mask still packs densely.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    for (int i = 0; i < NRET; i++) begin
      if (wr_valid[i]) begin
        mem_d[wptr_d] = wr_data[i*32 +: 32];
        wptr_d        = wptr_d + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data = mem_q[wptr_q - IDX_W'(1) - rd_idx];

endmodule

// File: rtl/retire_monitor.sv
// Commit/retire monitor: order tags, retire count, halt detection, stall watchdog
// and first-error capture. Define RETIRE_MONITOR_HIST_EN to build the PC history buffer.
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter  int NRET        = 2,
  parameter  int ORDER_W     = 64,
  parameter  int TIMEOUT     = 100000,
  parameter  int HALT_REPEAT = 2,
  parameter  int HIST_DEPTH  = 8,
  localparam int IDX_W       = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NRET-1:0]         commit_valid,
  input  logic [NRET*32-1:0]      commit_pc_rdata,
  input  logic [NRET*32-1:0]      commit_pc_wdata,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic [NRET*ORDER_W-1:0] order,
  output logic [ORDER_W-1:0]      retired_count,
  output logic                    halt,
  output logic                    timeout,
  output logic                    err,
  output logic [1:0]              err_code,
  output logic [CYCLE_W-1:0]      err_cycle,
  input  logic [IDX_W-1:0]        hist_idx,
  output logic [31:0]             hist_pc
);

  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam int HCNT_W = $clog2(HALT_REPEAT + 1);

  logic [ORDER_W-1:0]   retired_count_q, retired_count_d;
  logic                 halt_q, halt_d;
  logic [HCNT_W-1:0]    halt_cnt_q, halt_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d, err_new;
  logic [CYCLE_W-1:0]   err_cycle_q, err_cycle_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [MAX_LANES-1:0] valid_ext;
  logic                 any_commit;

  assign valid_ext  = MAX_LANES'(commit_valid);
  assign any_commit = |commit_valid;

  for (genvar gi = 0; gi < NRET; gi++) begin : g_order
    assign order[gi*ORDER_W +: ORDER_W] = retired_count_q + ORDER_W'(gi);
  end

  always_comb begin
    retired_count_d = retired_count_q + ORDER_W'(popcount(valid_ext));
    cycle_d         = cycle_q + CYCLE_W'(1);
  end

  // Self-loop run length; a non-loop lane resets it before younger lanes are seen.
  always_comb begin
    halt_cnt_d = halt_cnt_q;
    halt_d     = halt_q;
    for (int i = 0; i < NRET; i++) begin
      if (commit_valid[i]) begin
        if (commit_pc_wdata[i*32 +: 32] == commit_pc_rdata[i*32 +: 32]) begin
          if (halt_cnt_d != HCNT_W'(HALT_REPEAT)) begin
            halt_cnt_d = halt_cnt_d + HCNT_W'(1);
          end
          if (halt_cnt_d == HCNT_W'(HALT_REPEAT)) begin
            halt_d = 1'b1;
          end
        end else begin
          halt_cnt_d = '0;
        end
      end
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    if (enable) begin
      if (any_commit) begin
        idle_cnt_d = '0;
      end else if (!halt_q) begin
        if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
    end
  end

  // Priority order doubles as "lowest code wins" for simultaneous errors.
  always_comb begin
    err_new = ERR_NONE;
    if (enable) begin
      if (mem_read && mem_write) begin
        err_new = ERR_MEM_RW;
      end else if (!is_thermo(valid_ext)) begin
        err_new = ERR_LANE_GAP;
      end else if (any_commit && halt_q) begin
        err_new = ERR_POST_HALT;
      end
    end
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_cycle_d = err_cycle_q;
    if (!err_q && (err_new != ERR_NONE)) begin
      err_d       = 1'b1;
      err_code_d  = err_new;
      err_cycle_d = cycle_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count_q <= '0;
      halt_q          <= 1'b0;
      halt_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      timeout_q       <= 1'b0;
      err_q           <= 1'b0;
      err_code_q      <= ERR_NONE;
      err_cycle_q     <= '0;
      cycle_q         <= '0;
    end else begin
      retired_count_q <= retired_count_d;
      halt_q          <= halt_d;
      halt_cnt_q      <= halt_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      timeout_q       <= timeout_d;
      err_q           <= err_d;
      err_code_q      <= err_code_d;
      err_cycle_q     <= err_cycle_d;
      cycle_q         <= cycle_d;
    end
  end

  assign retired_count = retired_count_q;
  assign halt          = halt_q;
  assign timeout       = timeout_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign err_cycle     = err_cycle_q;

`ifdef RETIRE_MONITOR_HIST_EN
  retire_hist_buf #(
    .NRET       (NRET),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (commit_valid),
    .wr_data  (commit_pc_rdata),
    .rd_idx   (hist_idx),
    .rd_data  (hist_pc)
  );
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// Self-checking bench for retire_monitor (NRET=2, TIMEOUT=10, HALT_REPEAT=2, HIST_DEPTH=4):
// a reference model pushes expected register state per cycle, popped after the clock edge.
`timescale 1ns/1ps
module tb_retire_monitor;

  localparam int NRET        = 2;
  localparam int ORDER_W     = 64;
  localparam int TIMEOUT     = 10;
  localparam int HALT_REPEAT = 2;
  localparam int HIST_DEPTH  = 4;

  typedef struct {
    logic [63:0] count;
    logic        halt;
    logic        timeout;
    logic        err;
    logic [1:0]  code;
    logic [31:0] ecycle;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic [NRET-1:0]         commit_valid = '0;
  logic [NRET*32-1:0]      commit_pc_rdata = '0;
  logic [NRET*32-1:0]      commit_pc_wdata = '0;
  logic                    mem_read = 1'b0;
  logic                    mem_write = 1'b0;
  logic [NRET*ORDER_W-1:0] order;
  logic [ORDER_W-1:0]      retired_count;
  logic                    halt;
  logic                    timeout;
  logic                    err;
  logic [1:0]              err_code;
  logic [31:0]             err_cycle;
  logic [1:0]              hist_idx = '0;
  logic [31:0]             hist_pc;

  retire_monitor #(
    .NRET        (NRET),
    .ORDER_W     (ORDER_W),
    .TIMEOUT     (TIMEOUT),
    .HALT_REPEAT (HALT_REPEAT),
    .HIST_DEPTH  (HIST_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .commit_valid    (commit_valid),
    .commit_pc_rdata (commit_pc_rdata),
    .commit_pc_wdata (commit_pc_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .order           (order),
    .retired_count   (retired_count),
    .halt            (halt),
    .timeout         (timeout),
    .err             (err),
    .err_code        (err_code),
    .err_cycle       (err_cycle),
    .hist_idx        (hist_idx),
    .hist_pc         (hist_pc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_step   = 0;
  exp_t        sb[$];
  logic [63:0] m_count;
  logic        m_halt, m_timeout, m_err;
  int          m_hcnt, m_idle;
  logic [1:0]  m_code;
  logic [31:0] m_ecycle, m_cycle;
  logic [31:0] m_hist[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_count = '0; m_halt = 0; m_timeout = 0; m_err = 0;
    m_hcnt = 0; m_idle = 0; m_code = '0; m_ecycle = '0; m_cycle = '0;
    m_hist.delete();
    sb.delete();
  endtask

  // Called just after a rising edge; leaves the DUT out of reset at a rising edge + 1.
  task automatic do_reset();
    rst = 1'b0;
    commit_valid = '0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    model_reset();
    chk("rst_count", retired_count, 0);
    chk("rst_halt", halt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_ecycle", err_cycle, 0);
    chk("rst_hist", hist_pc, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic step(input logic [1:0] v, input logic [31:0] r0, input logic [31:0] w0,
                      input logic [31:0] r1, input logic [31:0] w1,
                      input logic mr, input logic mw);
    exp_t        e;
    logic        nh;
    int          c;
    logic [31:0] rr, ww;
    commit_valid    = v;
    commit_pc_rdata = {r1, r0};
    commit_pc_wdata = {w1, w0};
    mem_read        = mr;
    mem_write       = mw;
    #1;
    chk("order0", order[63:0], m_count);
    chk("order1", order[127:64], m_count + 64'd1);
    c = 0;
    if (enable) begin
      if (mr && mw) c = 1;
      else if (v == 2'b10) c = 2;
      else if (v != 2'b00 && m_halt) c = 3;
    end
    if (!m_err && c != 0) begin
      m_err = 1'b1; m_code = c[1:0]; m_ecycle = m_cycle;
    end
    nh = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rr = (i == 0) ? r0 : r1;
      ww = (i == 0) ? w0 : w1;
      if (v[i]) begin
        if (rr == ww) begin
          m_hcnt++;
          if (m_hcnt >= HALT_REPEAT) nh = 1'b1;
        end else begin
          m_hcnt = 0;
        end
        m_hist.push_back(rr);
      end
    end
    if (enable) begin
      if (v != 2'b00) m_idle = 0;
      else if (!m_halt) begin
        if (m_idle == TIMEOUT - 1) m_timeout = 1'b1;
        else m_idle++;
      end
    end
    m_count = m_count + v[0] + v[1];
    m_cycle = m_cycle + 32'd1;
    if (nh) m_halt = 1'b1;
    sb.push_back('{m_count, m_halt, m_timeout, m_err, m_code, m_ecycle});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("count", retired_count, e.count);
    chk("halt", halt, e.halt);
    chk("timeout", timeout, e.timeout);
    chk("err", err, e.err);
    chk("err_code", err_code, e.code);
    chk("err_cycle", err_cycle, e.ecycle);
    $display("step %0d en=%b valid=%b mr=%b mw=%b count=%0d halt=%b to=%b err=%b code=%0d",
             n_step, enable, v, mr, mw, retired_count, halt, timeout, err, err_code);
    n_step++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 4, 0, 4, 1'b0, 1'b0);
  endtask

  task automatic hist_check();
    logic [31:0] exp_pc;
    for (int k = 0; k < HIST_DEPTH; k++) begin
      hist_idx = k[1:0];
      #1;
`ifdef RETIRE_MONITOR_HIST_EN
      exp_pc = (k < m_hist.size()) ? m_hist[m_hist.size() - 1 - k] : 32'd0;
`else
      exp_pc = 32'd0;
`endif
      chk("hist", hist_pc, exp_pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;

    // Multi-lane order tags and retire count.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(2'b11, 32'h100 + 8*i, 32'h104 + 8*i, 32'h104 + 8*i, 32'h108 + 8*i, 0, 0);
    step(2'b01, 32'h200, 32'h204, 0, 0, 0, 0);
    chk("count7", retired_count, 7);
    chk("no_err_t1", err, 0);

    // Halt after two self-loops, then a post-halt commit error.
    do_reset();
    enable = 1'b1;
    step(2'b01, 32'h60, 32'h60, 0, 0, 0, 0);
    chk("halt_not_yet", halt, 0);
    step(2'b01, 32'h60, 32'h60, 0, 0, 0, 0);
    chk("halt_set", halt, 1);
    step(2'b01, 32'h64, 32'h68, 0, 0, 0, 0);
    chk("err_post_halt", err_code, 3);
    idle(3);
    chk("halt_sticky", halt, 1);

    // An intervening non-loop commit clears the run.
    do_reset();
    enable = 1'b1;
    step(2'b01, 32'h60, 32'h60, 0, 0, 0, 0);
    step(2'b01, 32'h64, 32'h68, 0, 0, 0, 0);
    step(2'b01, 32'h60, 32'h60, 0, 0, 0, 0);
    chk("halt_cleared", halt, 0);
    step(2'b11, 32'h64, 32'h68, 32'h70, 32'h70, 0, 0);
    chk("halt_lane_clear", halt, 0);
    step(2'b11, 32'h70, 32'h70, 32'h80, 32'h80, 0, 0);
    chk("halt_same_cycle", halt, 1);

    // Watchdog fires after TIMEOUT idle cycles.
    do_reset();
    enable = 1'b1;
    idle(9);
    chk("to_not_yet", timeout, 0);
    idle(1);
    chk("to_fire", timeout, 1);
    idle(2);
    chk("to_sticky", timeout, 1);

    // Commit on cycle 9 keeps the watchdog quiet.
    do_reset();
    enable = 1'b1;
    idle(9);
    step(2'b01, 32'h10, 32'h14, 0, 0, 0, 0);
    idle(9);
    chk("to_kicked", timeout, 0);

    // Disabled cycles do not advance the idle count.
    do_reset();
    enable = 1'b1;
    idle(5);
    enable = 1'b0;
    idle(10);
    enable = 1'b1;
    idle(4);
    chk("to_hold", timeout, 0);
    idle(1);
    chk("to_hold_fire", timeout, 1);

    // First error at cycle 20 wins; later errors ignored.
    do_reset();
    enable = 1'b0;
    step(2'b10, 0, 4, 0, 4, 1, 1);
    idle(19);
    chk("no_err_disabled", err, 0);
    enable = 1'b1;
    step(2'b10, 0, 4, 32'h8, 32'hC, 1, 1);
    chk("err_code1", err_code, 1);
    chk("err_cycle20", err_cycle, 20);
    step(2'b10, 0, 4, 32'h10, 32'h14, 0, 0);
    step(2'b01, 32'h20, 32'h24, 0, 0, 1, 1);
    chk("err_frozen", err_code, 1);
    chk("err_cycle_frozen", err_cycle, 20);

    // Lane-gap error alone.
    do_reset();
    enable = 1'b1;
    step(2'b10, 0, 0, 32'h40, 32'h44, 0, 0);
    chk("err_gap", err_code, 2);

    // PC history contents and clearing on reset.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) step(2'b01, 32'(4*i), 32'(4*i + 4), 0, 0, 0, 0);
    hist_check();
`ifdef RETIRE_MONITOR_HIST_EN
    hist_idx = 2'd0; #1; chk("hist0", hist_pc, 32'h14);
    hist_idx = 2'd3; #1; chk("hist3", hist_pc, 32'h08);
`endif
    @(posedge clk); #1;
    do_reset();
    hist_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
